// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the stage sequencer: stage indices, FSM encoding
// and memory-address select encodings.
package stage_sequencer_pkg;

  // Top-level sequencer state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } seq_state_e;

  // Fixed stage indices at the front of the pipeline walk
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;

  // Memory stage index for an n-stage sequencer
  function automatic int stg_mem(input int n);
    return n - 2;
  endfunction

  // WriteBack stage index for an n-stage sequencer
  function automatic int stg_wb(input int n);
    return n - 1;
  endfunction

  // Memory address source select
  localparam logic MA_SEL_PC = 1'b1;
  localparam logic MA_SEL_RZ = 1'b0;

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Memory wait counter. Counts non-stalled wait cycles and flags the wait
// cycle that brings the count up to MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Clear has priority; otherwise count enabled wait cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // The MEM_TIMEOUT-th counted wait cycle is the one that expires
  always_comb begin
    expired_o = en_i && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks an instruction through Fetch, Decode,
// Execute(s), Memory and WriteBack, generating datapath load strobes and
// memory requests. Fetch and Memory stages wait on MFC.
// Handshake: a memory request (MEM_Read/MEM_Write) is held while the stage
// waits; the stage completes in the first non-stalled cycle with MFC=1.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Run,
  input  logic                  Stall,
  input  logic                  NOP_FLAG,
  input  logic                  Mem_Access,
  input  logic                  Mem_Write,
  input  logic                  Reg_Write,
  input  logic                  PC_Update_Execute,
  input  logic                  MFC,
  output logic [STAGE_W-1:0]    Stage,
  output logic [NUM_STAGES-1:0] Stage_OneHot,
  output logic                  IR_Enable,
  output logic                  PC_Enable,
  output logic                  RA_Enable,
  output logic                  RB_Enable,
  output logic                  RZ_Enable,
  output logic                  RM_Enable,
  output logic                  RY_Enable,
  output logic                  RF_WRITE,
  output logic                  MEM_Read,
  output logic                  MEM_Write,
  output logic                  MA_Select,
  output logic                  Mem_Wait,
  output logic                  Mem_Timeout,
  output logic                  Instr_Done,
  output logic [CNT_W-1:0]      Instr_Count
);

  localparam logic [STAGE_W-1:0] S_FETCH   = STAGE_W'(STG_FETCH);
  localparam logic [STAGE_W-1:0] S_DECODE  = STAGE_W'(STG_DECODE);
  localparam logic [STAGE_W-1:0] S_LAST_EX = STAGE_W'(NUM_STAGES - 3);
  localparam logic [STAGE_W-1:0] S_MEM     = STAGE_W'(stg_mem(NUM_STAGES));
  localparam logic [STAGE_W-1:0] S_WB      = STAGE_W'(stg_wb(NUM_STAGES));

  seq_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_q, timeout_d;

  logic mem_stage_wait;
  logic advance;
  logic wait_en;
  logic wait_clr;
  logic wait_expired;

  // Wait counter only runs while RUN; any advance or leaving RUN clears it
  assign wait_clr = (state_q != RUN) || advance;

  mem_wait_timer #(
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i     (Clock),
    .rst_ni    (Reset_n),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  // Next-state and strobe generation; strobes fire only in advance cycles
  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    count_d        = count_q;
    timeout_d      = timeout_q;
    mem_stage_wait = 1'b0;
    advance        = 1'b0;
    wait_en        = 1'b0;
    IR_Enable      = 1'b0;
    PC_Enable      = 1'b0;
    RA_Enable      = 1'b0;
    RB_Enable      = 1'b0;
    RZ_Enable      = 1'b0;
    RM_Enable      = 1'b0;
    RY_Enable      = 1'b0;
    RF_WRITE       = 1'b0;
    MEM_Read       = 1'b0;
    MEM_Write      = 1'b0;
    MA_Select      = MA_SEL_PC;
    Mem_Wait       = 1'b0;
    Instr_Done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = RUN;
          stage_d = S_FETCH;
        end
      end

      RUN: begin
        mem_stage_wait = (stage_q == S_FETCH) ||
                         ((stage_q == S_MEM) && Mem_Access);
        advance        = !Stall && (!mem_stage_wait || MFC);
        wait_en        = mem_stage_wait && !MFC && !Stall;

        if (stage_q == S_FETCH) begin
          MA_Select = MA_SEL_PC;
          MEM_Read  = 1'b1;
          Mem_Wait  = !MFC;
          if (advance) begin
            IR_Enable = 1'b1;
            PC_Enable = 1'b1;
            stage_d   = S_DECODE;
          end
        end else if (stage_q == S_DECODE) begin
          if (advance) begin
            RA_Enable = 1'b1;
            RB_Enable = 1'b1;
            if (NOP_FLAG) begin
              // NOP retires early and skips the remaining stages
              Instr_Done = 1'b1;
              stage_d    = S_FETCH;
              if (!Run) begin
                state_d = IDLE;
              end
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end
        end else if (stage_q == S_MEM) begin
          if (Mem_Access) begin
            MA_Select = MA_SEL_RZ;
            MEM_Read  = !Mem_Write;
            MEM_Write = Mem_Write;
            Mem_Wait  = !MFC;
          end
          if (advance) begin
            RY_Enable = 1'b1;
            stage_d   = S_WB;
          end
        end else if (stage_q == S_WB) begin
          if (advance) begin
            RF_WRITE   = Reg_Write;
            Instr_Done = 1'b1;
            count_d    = count_q + CNT_W'(1);
            stage_d    = S_FETCH;
            if (!Run) begin
              state_d = IDLE;
            end
          end
        end else begin
          // Execute stages; only the last one loads results
          if (advance) begin
            if (stage_q == S_LAST_EX) begin
              RZ_Enable = 1'b1;
              RM_Enable = Mem_Write;
              PC_Enable = PC_Update_Execute;
            end
            stage_d = stage_q + STAGE_W'(1);
          end
        end

        // Expiry only happens in a wait cycle, so no strobe is active here
        if (wait_expired) begin
          state_d   = FAULT;
          timeout_d = 1'b1;
        end
      end

      FAULT: begin
        MA_Select = 1'b0;
      end

      default: begin
        state_d = IDLE;
        stage_d = S_FETCH;
      end
    endcase
  end

  // State, stage, retire counter and sticky fault registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Status outputs; FAULT forces everything but Mem_Timeout low
  always_comb begin
    Stage        = (state_q == FAULT) ? '0 : stage_q;
    Stage_OneHot = (state_q == RUN) ? (NUM_STAGES'(1) << stage_q) : '0;
    Instr_Count  = (state_q == FAULT) ? '0 : count_q;
    Mem_Timeout  = timeout_q;
  end

endmodule
